// File: rtl/cic_decimator_mc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Package : cic_pkg                                                    |
// | Shared types and helpers for the multichannel CIC decimator:         |
// |   cic_state_e - comb/scale engine states                             |
// |   DC_STEP     - DC tracker step size                                 |
// |   sat()       - clamp a signed value into an out_w-bit signed range  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COMB  = 3'd2,
    DC1   = 3'd3,
    DC2   = 3'd4,
    SCALE = 3'd5,
    OUT   = 3'd6
  } cic_state_e;

  localparam int DC_STEP = 4;

  // Result is still 64 bits wide; the caller truncates to out_w bits,
  // which is lossless because the value is already inside that range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int                 out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      r = hi;
    else if (x < lo) r = lo;
    else             r = x;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_decimator_mc_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Interface : cic_decimator_mc_if                                      |
// | PCM output stream (valid/ready) of the CIC decimator.                |
// |   out_valid - PCM word available          (master -> slave)          |
// |   out_ready - sink accepts word           (slave  -> master)         |
// |   out_ch    - channel index of out_data   (master -> slave)          |
// |   out_data  - signed PCM sample           (master -> slave)          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface cic_decimator_mc_if #(
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [OUT_W-1:0] out_data;

  modport master (output out_valid, output out_ch, output out_data, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_data, output out_ready);
endinterface
`default_nettype wire

// File: rtl/cic_integrator_bank.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : cic_integrator_bank                                         |
// | Per-channel STAGES-deep CIC integrator chains plus the frame         |
// | snapshot of the last integrator of every channel.                    |
// |   clk, rst_n  - clock, async active-low reset                        |
// |   stb_sample  - advance all integrators by one PDM sample            |
// |   pdm_din     - one PDM bit per channel (1 => +1, 0 => -1)           |
// |   snap_en     - capture the last-stage values (pre-update)           |
// |   snap_q      - captured frame, one W-bit word per channel           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cic_integrator_bank #(
  parameter int CHANNELS = 2,
  parameter int STAGES   = 4,
  parameter int W        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stb_sample,
  input  logic [CHANNELS-1:0]          pdm_din,
  input  logic                         snap_en,
  output logic [CHANNELS-1:0][W-1:0]   snap_q
);

  logic [W-1:0]                integ_q [CHANNELS][STAGES];
  logic [W-1:0]                integ_d [CHANNELS][STAGES];
  logic [CHANNELS-1:0][W-1:0]  snap_d;

  // Every stage reads only integ_q, so all stages step together on the
  // old values. Modulo-2^W wrap is intentional: the combs undo it.
  always_comb begin
    integ_d = integ_q;
    snap_d  = snap_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (snap_en) snap_d[c] = integ_q[c][STAGES-1];
      if (stb_sample) begin
        integ_d[c][0] = pdm_din[c] ? integ_q[c][0] + W'(1) : integ_q[c][0] - W'(1);
        for (int k = 1; k < STAGES; k++) begin
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        snap_q[c] <= '0;
        for (int k = 0; k < STAGES; k++) integ_q[c][k] <= '0;
      end
    end else begin
      integ_q <= integ_d;
      snap_q  <= snap_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cic_decimator_mc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : cic_decimator_mc                                            |
// | Multichannel PDM-to-PCM CIC decimator. Per-channel integrators run   |
// | at the PDM strobe rate; one time-shared comb/scale engine serves     |
// | all channels at the decimated rate with saturating output.           |
// |   clk, rst_n   - clock, async active-low reset                       |
// |   stb_sample   - one-cycle strobe, sample all pdm_din bits           |
// |   pdm_din      - PDM bits, one per channel                           |
// |   pcm          - PCM stream (out_valid/out_ready/out_ch/out_data)    |
// |   busy         - comb engine active                                  |
// |   overrun      - sticky: decimation tick arrived while busy          |
// |   clr_overrun  - clears overrun (a new overrun wins)                 |
// | Build option : CIC_DC_REMOVE_EN adds a per-channel DC tracker        |
// |                (DC1/DC2 states) between the combs and the scaler.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cic_decimator_mc
  import cic_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int STAGES   = 4,
  parameter int W        = 32,
  parameter int DECIM    = 125,
  parameter int SHIFT    = 12,
  parameter int OUT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stb_sample,
  input  logic [CHANNELS-1:0]       pdm_din,
  cic_decimator_mc_if.master        pcm,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      clr_overrun
);

  localparam int c_ch_w  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_s_w   = (STAGES > 1)   ? $clog2(STAGES)   : 1;
  localparam int c_cnt_w = (DECIM > 1)    ? $clog2(DECIM)    : 1;

  cic_state_e                 state_q, state_d;
  logic [c_cnt_w-1:0]         cnt_q, cnt_d;
  logic [c_ch_w-1:0]          ch_q, ch_d;
  logic [c_s_w-1:0]           s_q, s_d;
  logic signed [W-1:0]        rb_q, rb_d;
  logic [W-1:0]               d_q [CHANNELS][STAGES];
  logic [W-1:0]               d_d [CHANNELS][STAGES];
`ifdef CIC_DC_REMOVE_EN
  logic [W-1:0]               dc_q [CHANNELS];
  logic [W-1:0]               dc_d [CHANNELS];
`endif
  logic                       out_valid_q, out_valid_d;
  logic [c_ch_w-1:0]          out_ch_q, out_ch_d;
  logic signed [OUT_W-1:0]    out_data_q, out_data_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic                       tick;
  logic                       snap_en;
  logic signed [63:0]         scaled;
  logic [CHANNELS-1:0][W-1:0] snap;

  cic_integrator_bank #(
    .CHANNELS (CHANNELS),
    .STAGES   (STAGES),
    .W        (W)
  ) u_integ (
    .clk        (clk),
    .rst_n      (rst_n),
    .stb_sample (stb_sample),
    .pdm_din    (pdm_din),
    .snap_en    (snap_en),
    .snap_q     (snap)
  );

  assign tick = stb_sample && (cnt_q == c_cnt_w'(DECIM - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (stb_sample) cnt_d = tick ? '0 : cnt_q + c_cnt_w'(1);
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    s_d         = s_q;
    rb_d        = rb_q;
    d_d         = d_q;
`ifdef CIC_DC_REMOVE_EN
    dc_d        = dc_q;
`endif
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    snap_en     = 1'b0;
    scaled      = 64'(rb_q >>> SHIFT);
    // A tick while the engine is still working drops that frame; the
    // set term is OR-ed last so it beats a simultaneous clear.
    overrun_d   = (overrun_q && !clr_overrun) || (tick && busy_q);

    case (state_q)
      IDLE: begin
        if (tick) begin
          snap_en = 1'b1;
          busy_d  = 1'b1;
          ch_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        rb_d    = snap[ch_q];
        s_d     = '0;
        state_d = COMB;
      end
      COMB: begin
        rb_d           = rb_q - d_q[ch_q][s_q];
        d_d[ch_q][s_q] = rb_q;
        s_d            = s_q + c_s_w'(1);
        if (s_q == c_s_w'(STAGES - 1)) begin
`ifdef CIC_DC_REMOVE_EN
          state_d = DC1;
`else
          state_d = SCALE;
`endif
        end
      end
`ifdef CIC_DC_REMOVE_EN
      DC1: begin
        rb_d    = rb_q - dc_q[ch_q];
        state_d = DC2;
      end
      DC2: begin
        // Tracker chases the residual: step toward the sign of the
        // already-corrected sample so the output dithers around zero.
        dc_d[ch_q] = rb_q[W-1] ? dc_q[ch_q] - W'(DC_STEP) : dc_q[ch_q] + W'(DC_STEP);
        state_d    = SCALE;
      end
`endif
      SCALE: begin
        out_data_d  = OUT_W'(sat(scaled, OUT_W));
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (pcm.out_ready) begin
          out_valid_d = 1'b0;
          if (ch_q == c_ch_w'(CHANNELS - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + c_ch_w'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      s_q         <= '0;
      rb_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < STAGES; k++) d_q[c][k] <= '0;
`ifdef CIC_DC_REMOVE_EN
        dc_q[c] <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      s_q         <= s_d;
      rb_q        <= rb_d;
      d_q         <= d_d;
`ifdef CIC_DC_REMOVE_EN
      dc_q        <= dc_d;
`endif
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm.out_valid = out_valid_q;
  assign pcm.out_ch    = out_ch_q;
  assign pcm.out_data  = out_data_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator_mc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : tb_cic_decimator_mc                                         |
// | Scoreboard bench for cic_decimator_mc. Instance 0 uses a small       |
// | configuration (STAGES=2, W=16, DECIM=4, SHIFT=0); instance 1 uses    |
// | the default parameters. A reference model computes each PCM word    |
// | when the decimation tick is driven and queues it; the monitor pops  |
// | and compares on every out_valid && out_ready.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_cic_decimator_mc;

  localparam int NCH = 2;
  localparam int OW  = 16;
  localparam int S0 = 2,  W0 = 16, D0 = 4,   SH0 = 0;
  localparam int S1 = 4,  W1 = 32, D1 = 125, SH1 = 12;
`ifdef CIC_DC_REMOVE_EN
  localparam int FR_A     = 12;
  localparam int RST_WAIT = S0 + 6;
`else
  localparam int FR_A     = 6;
  localparam int RST_WAIT = S0 + 4;
`endif

  typedef struct {
    int     ch;
    longint data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stb [2];
  logic [NCH-1:0]   pdm [2];
  logic             clr [2];
  logic             busy0, busy1, ovr0, ovr1;

  always #5 clk = ~clk;

  cic_decimator_mc_if #(.CHANNELS(NCH), .OUT_W(OW)) if0 ();
  cic_decimator_mc_if #(.CHANNELS(NCH), .OUT_W(OW)) if1 ();

  cic_decimator_mc #(
    .CHANNELS(NCH), .STAGES(S0), .W(W0), .DECIM(D0), .SHIFT(SH0), .OUT_W(OW)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .stb_sample(stb[0]), .pdm_din(pdm[0]),
    .pcm(if0), .busy(busy0), .overrun(ovr0), .clr_overrun(clr[0])
  );

  cic_decimator_mc u_dut1 (
    .clk(clk), .rst_n(rst_n), .stb_sample(stb[1]), .pdm_din(pdm[1]),
    .pcm(if1), .busy(busy1), .overrun(ovr1), .clr_overrun(clr[1])
  );

  // Reference model state, indexed [instance][channel][stage]
  int     p_st  [2] = '{S0, S1};
  int     p_w   [2] = '{W0, W1};
  int     p_dec [2] = '{D0, D1};
  int     p_sh  [2] = '{SH0, SH1};
  longint integ [2][NCH][8];
  longint dly   [2][NCH][8];
  longint dcm   [2][NCH];
  int     cnt   [2];
  int     acc_fr  [2];
  int     done_fr [2] = '{0, 0};
  longint last_val [2][NCH];
  exp_t   eq0 [$];
  exp_t   eq1 [$];
  exp_t   me;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    return v & ((longint'(1) << w) - 1);
  endfunction

  function automatic longint sxw(input longint v, input int w);
    longint u;
    u = wrapw(v, w);
    if (u[w-1]) u = u - (longint'(1) << w);
    return u;
  endfunction

  // One decimated frame for instance m, from the pre-update integrators.
  function automatic void model_frame(input int m);
    longint rb, t, v, hi;
    int w;
    exp_t e;
    w  = p_w[m];
    hi = (longint'(1) << (OW - 1)) - 1;
    for (int c = 0; c < NCH; c++) begin
      rb = integ[m][c][p_st[m]-1];
      for (int s = 0; s < p_st[m]; s++) begin
        t = wrapw(rb - dly[m][c][s], w);
        dly[m][c][s] = rb;
        rb = t;
      end
`ifdef CIC_DC_REMOVE_EN
      rb = wrapw(rb - dcm[m][c], w);
      dcm[m][c] = wrapw(dcm[m][c] + ((sxw(rb, w) < 0) ? -4 : 4), w);
`endif
      v = sxw(rb, w) >>> p_sh[m];
      if (v > hi) v = hi;
      if (v < -hi - 1) v = -hi - 1;
      e.ch = c;
      e.data = v;
      if (m == 0) eq0.push_back(e);
      else        eq1.push_back(e);
    end
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      acc_fr[m] = done_fr[m];
      for (int c = 0; c < NCH; c++) begin
        dcm[m][c] = 0;
        for (int k = 0; k < 8; k++) begin
          integ[m][c][k] = 0;
          dly[m][c][k]   = 0;
        end
      end
    end
    eq0.delete();
    eq1.delete();
  endtask

  // Drive one PDM strobe on instance m and advance the model with it.
  task automatic strobe(input int m, input logic [NCH-1:0] bits, input int gap);
    bit tk;
    tk = (cnt[m] == p_dec[m] - 1);
    if (tk && (acc_fr[m] == done_fr[m])) begin
      acc_fr[m]++;
      model_frame(m);
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = p_st[m] - 1; k >= 1; k--)
        integ[m][c][k] = wrapw(integ[m][c][k] + integ[m][c][k-1], p_w[m]);
      integ[m][c][0] = wrapw(integ[m][c][0] + (bits[c] ? 1 : -1), p_w[m]);
    end
    cnt[m] = tk ? 0 : cnt[m] + 1;
    pdm[m] = bits;
    stb[m] = 1'b1;
    @(posedge clk); #1;
    stb[m] = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: sampled mid-cycle, i.e. the handshake the next edge takes.
  always @(negedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready) begin
      if (eq0.size() == 0) check("unexp_out0", 1, 0);
      else begin
        me = eq0.pop_front();
        check("out_ch0", longint'(if0.out_ch), me.ch);
        check("out_data0", $signed(if0.out_data), me.data);
        last_val[0][me.ch] = $signed(if0.out_data);
        if (me.ch == NCH - 1) done_fr[0]++;
      end
    end
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (eq1.size() == 0) check("unexp_out1", 1, 0);
      else begin
        me = eq1.pop_front();
        check("out_ch1", longint'(if1.out_ch), me.ch);
        check("out_data1", $signed(if1.out_data), me.data);
        last_val[1][me.ch] = $signed(if1.out_data);
        if (me.ch == NCH - 1) done_fr[1]++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      stb[m] = 1'b0; clr[m] = 1'b0; pdm[m] = '0;
    end
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    model_reset();
    settle(3);

    // Reset state
    check("rst_valid", if0.out_valid, 0);
    check("rst_ch",    if0.out_ch, 0);
    check("rst_data",  $signed(if0.out_data), 0);
    check("rst_busy",  busy0, 0);
    check("rst_ovr",   ovr0, 0);
    rst_n = 1'b1;
    settle(2);

    // A: all-ones on both channels
    repeat (FR_A * D0) strobe(0, 2'b11, 3);
    settle(20);
`ifdef CIC_DC_REMOVE_EN
    check("dc_ch0_near0", (last_val[0][0] >= -4 && last_val[0][0] <= 4), 1);
    check("dc_ch1_near0", (last_val[0][1] >= -4 && last_val[0][1] <= 4), 1);
`else
    check("ones_ch0", last_val[0][0], 16);
    check("ones_ch1", last_val[0][1], 16);
`endif

    // B: alternating 1,0 on ch0, constant 0 on ch1
    for (int i = 0; i < 10 * D0; i++) strobe(0, {1'b0, (i % 2 == 0)}, 3);
    settle(20);
`ifndef CIC_DC_REMOVE_EN
    check("alt_ch0",  last_val[0][0], 0);
    check("zero_ch1", last_val[0][1], -16);
`endif

    // C: sink stalled across two ticks -> second frame dropped
    if0.out_ready = 1'b0;
    repeat (2 * D0) strobe(0, 2'b11, 3);
    settle(4);
    check("ovr_set",   ovr0, 1);
    check("busy_hold", busy0, 1);
    for (int i = 0; i < 3; i++) begin
      if (eq0.size() == 0) check("hold_queue", 0, 1);
      else begin
        check("hold_valid", if0.out_valid, 1);
        check("hold_ch",    longint'(if0.out_ch), eq0[0].ch);
        check("hold_data",  $signed(if0.out_data), eq0[0].data);
      end
      settle(1);
    end
    clr[0] = 1'b1;
    settle(1);
    clr[0] = 1'b0;
    check("ovr_clr", ovr0, 0);
    if0.out_ready = 1'b1;
    settle(20);
    repeat (3 * D0) strobe(0, 2'b10, 3);
    settle(20);
    check("ovr_stays0", ovr0, 0);

    // D: reset while the comb engine works on ch1
    repeat (D0 - 1) strobe(0, 2'b01, 3);
    strobe(0, 2'b01, 0);
    repeat (RST_WAIT - 1) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", if0.out_valid, 0);
    check("arst_ch",    if0.out_ch, 0);
    check("arst_data",  $signed(if0.out_data), 0);
    check("arst_busy",  busy0, 0);
    check("arst_ovr",   ovr0, 0);
    model_reset();
    settle(2);
    rst_n = 1'b1;
    settle(1);
    repeat (D0 - 1) strobe(0, 2'b11, 3);
    settle(10);
    check("no_out_pre_tick", if0.out_valid, 0);
    check("no_busy_pre_tick", busy0, 0);
    repeat (5 * D0 + 1) strobe(0, 2'b11, 3);
    settle(20);

    // E: default configuration, saturation both ways
    repeat (6 * D1) strobe(1, 2'b11, 0);
    settle(30);
    check("sat_pos_ch0", last_val[1][0], 32767);
    check("sat_pos_ch1", last_val[1][1], 32767);
    repeat (8 * D1) strobe(1, 2'b00, 0);
    settle(30);
    check("sat_neg_ch0", last_val[1][0], -32768);
    check("sat_neg_ch1", last_val[1][1], -32768);

    check("q0_drained", eq0.size(), 0);
    check("q1_drained", eq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
